// File: rtl/sysid_info_regs_if.sv
// Avalon-MM slave bus bundle for sysid_info_regs.
// Signals:
//   address       word address (ADDR_WIDTH bits)
//   read / write  access strobes
//   writedata     32-bit write data
//   byteenable    write byte lanes
//   readdata      registered read data (slave output)
//   readdatavalid one-cycle pulse qualifying readdata (slave output)
interface sysid_info_regs_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  read;
  logic                  write;
  logic [31:0]           writedata;
  logic [3:0]            byteenable;
  logic [31:0]           readdata;
  logic                  readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_info_regs.sv
// System-ID / platform-info register block on the lightweight HPS-to-FPGA bridge.
// Serves a read-only ID and build timestamp, a byte-writable scratch register,
// a free-running 64-bit uptime counter with an atomic high-word snapshot,
// a control register and a parametrised array of read-only user words.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high reset
//   bus    Avalon-MM slave (address/read/write/writedata/byteenable in,
//          readdata/readdatavalid out, fixed read latency of one cycle)
module sysid_info_regs #(
  parameter logic [31:0]                  ID_VALUE       = 32'hA0C0FFEE,
  parameter logic [31:0]                  TIMESTAMP      = 32'h00000000,
  parameter int                           ADDR_WIDTH     = 4,
  parameter int                           NUM_USER_WORDS = 2,
  parameter logic [NUM_USER_WORDS*32-1:0] USER_WORDS     = '0,
  parameter logic [31:0]                  SCRATCH_RESET  = 32'h00000000
) (
  input  logic               clock,
  input  logic               reset,
  sysid_info_regs_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_TSTAMP  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_SCRATCH = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_UP_LO   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_UP_HI   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_CONTROL = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] A_NUSER   = ADDR_WIDTH'(6);
  localparam int                    USER_BASE = 7;

  logic [31:0] readdata_q,  readdata_d;
  logic        rdvalid_q,   rdvalid_d;
  logic [31:0] scratch_q,   scratch_d;
  logic [63:0] uptime_q,    uptime_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        ctrl_en_q,   ctrl_en_d;

  logic [31:0] rd_mux;
  logic        wr_en;
  logic        clear;

  // A simultaneous read wins; the write in that cycle is discarded.
  assign wr_en = bus.write & ~bus.read;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      A_ID:      rd_mux = ID_VALUE;
      A_TSTAMP:  rd_mux = TIMESTAMP;
      A_SCRATCH: rd_mux = scratch_q;
      A_UP_LO:   rd_mux = uptime_q[31:0];
      A_UP_HI:   rd_mux = hi_shadow_q;
      A_CONTROL: rd_mux = {31'b0, ctrl_en_q};
      A_NUSER:   rd_mux = 32'(NUM_USER_WORDS);
      default: begin
        for (int k = 0; k < NUM_USER_WORDS; k++) begin
          if (bus.address == ADDR_WIDTH'(USER_BASE + k))
            rd_mux = USER_WORDS[32*k +: 32];
        end
      end
    endcase
  end

  always_comb begin
    readdata_d  = readdata_q;
    rdvalid_d   = bus.read;
    scratch_d   = scratch_q;
    ctrl_en_d   = ctrl_en_q;
    hi_shadow_d = hi_shadow_q;
    clear       = 1'b0;

    if (bus.read) begin
      readdata_d = rd_mux;
      // Capture the high word alongside the low-word read so a following
      // high-word read is coherent even if the low word carries in between.
      if (bus.address == A_UP_LO)
        hi_shadow_d = uptime_q[63:32];
    end

    if (wr_en && bus.address == A_SCRATCH) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i])
          scratch_d[8*i +: 8] = bus.writedata[8*i +: 8];
      end
    end

    if (wr_en && bus.address == A_CONTROL && bus.byteenable[0]) begin
      ctrl_en_d = bus.writedata[0];
      clear     = bus.writedata[1];
    end

    // Clear beats increment in the same cycle.
    if (clear)
      uptime_d = '0;
    else if (ctrl_en_q)
      uptime_d = uptime_q + 64'd1;
    else
      uptime_d = uptime_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata_q  <= '0;
      rdvalid_q   <= 1'b0;
      scratch_q   <= SCRATCH_RESET;
      uptime_q    <= '0;
      hi_shadow_q <= '0;
      ctrl_en_q   <= 1'b1;
    end else begin
      readdata_q  <= readdata_d;
      rdvalid_q   <= rdvalid_d;
      scratch_q   <= scratch_d;
      uptime_q    <= uptime_d;
      hi_shadow_q <= hi_shadow_d;
      ctrl_en_q   <= ctrl_en_d;
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = rdvalid_q;

endmodule
